mdu_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the pipeline's EX stage. It sequences the 32-bit ALU through an iterative shift-add multiply or restoring divide, and delivers a 2×Width result into HI/LO. The pipeline stalls on `busy_o` and consumes `hi_o`/`lo_o` when `done_o` pulses. One ALU instance is private to this block; the EX-stage ALU is untouched.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/alu.sv | 36 +++
 rtl/mdu_seq.sv | 177 +++++++++++++++++
 tb/tb_mdu_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU control codes and multiply/divide sequencer types
//
// Purpose: constants and enums shared by alu and mdu_seq.
// Ports:   none (package).
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } mdu_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 3-bit-controlled integer ALU
//
// Purpose: and/or/add/sub/shift/slt on two Width-bit operands.
// Ports:
//   a, b  in  Width  operands (b[log2 Width-1:0] is the shift amount)
//   ctrl  in  3      operation select (ALU_* codes from mips_pkg)
//   y     out Width  result
module alu
    import mips_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic [2:0]       ctrl,
    output logic [Width-1:0] y
);

    localparam int ShW = $clog2(Width);

    always_comb begin
        y = '0;
        unique case (ctrl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SLL: y = a << b[ShW-1:0];
            ALU_SRL: y = a >> b[ShW-1:0];
            ALU_SRA: y = $signed(a) >>> b[ShW-1:0];
            ALU_SUB: y = a - b;
            ALU_SLT: y = {{(Width-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative multiply/divide sequencer producing HI/LO
//
// Purpose: shift-add multiply and restoring divide, one bit per cycle,
//          using a private ALU for the per-step add/sub.
// Ports:
//   clk_i    in  1      clock
//   rst_ni   in  1      asynchronous active-low reset
//   start_i  in  1      request (accepted in IDLE only)
//   op_i     in  2      00 multu, 01 mult, 10 divu, 11 div
//   a_i      in  Width  multiplicand / dividend
//   b_i      in  Width  multiplier / divisor
//   flush_i  in  1      abort operation in flight
//   busy_o   out 1      operation in progress
//   done_o   out 1      one-cycle result-valid pulse
//   hi_o     out Width  product high half / remainder
//   lo_o     out Width  product low half / quotient
module mdu_seq
    import mips_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);

    localparam int CntW = $clog2(Width);

    mdu_state_t        state_q, state_d;
    mdu_op_t           op_q;
    logic [Width-1:0]  a_q, b_q;
    // addend_q: multiplicand (mult) or divisor (div)
    // shreg_q:  multiplier shifting out / dividend shifting out, quotient shifting in
    // acc_q:    product high half (mult) or partial remainder (div)
    logic [Width-1:0]  addend_q, shreg_q, acc_q;
    logic [CntW-1:0]   cnt_q;
    logic              neg_quo_q, neg_rem_q;
    logic [Width-1:0]  hi_q, lo_q;
    logic              busy_q, done_q;

    logic              is_div, is_signed;
    logic [Width-1:0]  abs_a, abs_b;
    logic [Width:0]    shifted;
    logic [2:0]        alu_ctrl;
    logic [Width-1:0]  alu_a, alu_y;
    logic              carry, no_borrow;
    logic [Width:0]    step_sum;
    logic [2*Width-1:0] product, neg_product;
    logic [Width-1:0]  fix_hi, fix_lo;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];

    assign abs_a = (is_signed && a_q[Width-1]) ? -a_q : a_q;
    assign abs_b = (is_signed && b_q[Width-1]) ? -b_q : b_q;

    // Remainder shifted left with the next dividend bit pulled in; one bit
    // wider so a remainder above half-range is not lost before the compare.
    assign shifted = {acc_q, shreg_q[Width-1]};

    assign alu_ctrl = is_div ? ALU_SUB : ALU_ADD;
    assign alu_a    = is_div ? shifted[Width-1:0] : acc_q;

    alu #(.Width(Width)) u_alu (
        .a    (alu_a),
        .b    (addend_q),
        .ctrl (alu_ctrl),
        .y    (alu_y)
    );

    // Carry of the zero-extended add: the truncated sum wrapped below an operand.
    assign carry     = (alu_y < addend_q);
    // Difference is non-negative if the extra shifted bit is set or the low
    // Width bits already cover the divisor; then the ALU result is exact.
    assign no_borrow = shifted[Width] || (shifted[Width-1:0] >= addend_q);

    assign step_sum = shreg_q[0] ? {carry, alu_y} : {1'b0, acc_q};

    assign product     = {acc_q, shreg_q};
    assign neg_product = -product;

    always_comb begin
        fix_hi = acc_q;
        fix_lo = shreg_q;
        if (is_div) begin
            if (neg_quo_q) fix_lo = -shreg_q;
            if (neg_rem_q) fix_hi = -acc_q;
        end else if (neg_quo_q) begin
            fix_hi = neg_product[2*Width-1:Width];
            fix_lo = neg_product[Width-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_PREP;
            ST_PREP:  state_d = ST_ITER;
            ST_ITER:  if (cnt_q == '0) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            op_q      <= MDU_MULTU;
            a_q       <= '0;
            b_q       <= '0;
            addend_q  <= '0;
            shreg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_PREP) || (state_d == ST_ITER) || (state_d == ST_FIXUP);
            done_q  <= (state_d == ST_DONE);
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i && !flush_i) begin
                        op_q <= mdu_op_t'(op_i);
                        a_q  <= a_i;
                        b_q  <= b_i;
                    end
                end
                ST_PREP: begin
                    addend_q  <= is_div ? abs_b : abs_a;
                    shreg_q   <= is_div ? abs_a : abs_b;
                    acc_q     <= '0;
                    cnt_q     <= CntW'(Width - 1);
                    neg_quo_q <= is_signed && (a_q[Width-1] ^ b_q[Width-1]);
                    neg_rem_q <= is_signed && a_q[Width-1];
                end
                ST_ITER: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (is_div) begin
                        acc_q   <= no_borrow ? alu_y : shifted[Width-1:0];
                        shreg_q <= {shreg_q[Width-2:0], no_borrow};
                    end else begin
                        acc_q   <= step_sum[Width:1];
                        shreg_q <= {step_sum[0], shreg_q[Width-1:1]};
                    end
                end
                ST_FIXUP: begin
                    if (!flush_i) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed self-checking bench for mdu_seq
module tb_mdu_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    mdu_seq #(.Width(32)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the current cycle is cycle 0 (start presented).
    // Returns at the negedge of the done cycle or of cycle max_cyc.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_cyc, input int flush_cyc, input int max_cyc,
                          output int lat, output logic got_done, output logic busy_ok);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        lat = 0; got_done = 1'b0; busy_ok = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            flush_i = 1'b0;
            if (done_o) begin
                got_done = 1'b1;
                lat = cyc;
                if (busy_o) busy_ok = 1'b0;
                break;
            end
            if (!busy_o) busy_ok = 1'b0;
            if (cyc == poke_cyc) begin
                op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
            end
            if (cyc == flush_cyc) flush_i = 1'b1;
        end
    endtask

    task automatic simple_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        logic gd, bok;
        @(negedge clk_i);
        run_op(op, a, b, 0, 0, 60, lat, gd, bok);
        check({tag, "_lat"}, 64'(lat), 64'd35);
        check({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic gd, bok;

        #12;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // multu max*max, plus busy profile and done pulse width
        @(negedge clk_i);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 60, lat, gd, bok);
        check("multu_lat", 64'(lat), 64'd35);
        check("multu_busy", 64'(bok), 64'd1);
        check("multu_hi", 64'(hi_o), 64'hFFFFFFFE);
        check("multu_lo", 64'(lo_o), 64'h00000001);
        @(negedge clk_i);
        check("done_pulse", 64'(done_o), 64'd0);
        check("hold_hi", 64'(hi_o), 64'hFFFFFFFE);

        // mult -3 * 5 with an ignored start in cycle 10
        @(negedge clk_i);
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 10, 0, 60, lat, gd, bok);
        check("mult_lat", 64'(lat), 64'd35);
        check("mult_hi", 64'(hi_o), 64'hFFFFFFFF);
        check("mult_lo", 64'(lo_o), 64'hFFFFFFF1);
        @(negedge clk_i);
        check("mult_no_restart", 64'(busy_o), 64'd0);

        simple_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        simple_op("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        simple_op("divu_zero", OP_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        simple_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // flush in cycle 20; prior result is the overflow case above
        @(negedge clk_i);
        run_op(OP_MULTU, 32'd3, 32'd4, 0, 20, 21, lat, gd, bok);
        check("flush_no_done", 64'(gd), 64'd0);
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_hi", 64'(hi_o), 64'h00000000);
        check("flush_lo", 64'(lo_o), 64'h80000000);
        @(negedge clk_i);
        check("flush_c22_done", 64'(done_o), 64'd0);
        run_op(OP_MULTU, 32'd3, 32'd4, 0, 0, 60, lat, gd, bok);
        check("post_flush_lat", 64'(lat), 64'd35);
        check("post_flush_hi", 64'(hi_o), 64'd0);
        check("post_flush_lo", 64'(lo_o), 64'd12);

        // asynchronous reset mid-ITER
        @(negedge clk_i);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 15, lat, gd, bok);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_done", 64'(done_o), 64'd0);
        check("arst_hi", 64'(hi_o), 64'd0);
        check("arst_lo", 64'(lo_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        simple_op("post_rst_divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
